// File: rtl/adaptive_traffic_ctrl_n.sv
// adaptive_traffic_ctrl_n: N-approach adaptive traffic-light controller with integrated timer, all-red clearance and emergency preemption
module adaptive_traffic_ctrl_n #(
  parameter int N_APPROACH  = 4,
  parameter int SENSOR_W    = 2,
  parameter int TIMER_W     = 6,
  parameter int GREEN_TIME  = 30,
  parameter int ORANGE_TIME = 3,
  parameter int ALLRED_TIME = 1,
  parameter int MIN_GREEN   = 5,
  parameter int MAX_EXT     = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             tick,
  input  logic [N_APPROACH*SENSOR_W-1:0]   sensor,
  input  logic                             emg_req,
  input  logic [$clog2(N_APPROACH)-1:0]    emg_sel,
  output logic [3*N_APPROACH-1:0]          lights,
  output logic [$clog2(N_APPROACH)-1:0]    active_idx,
  output logic [1:0]                       phase,
  output logic [TIMER_W-1:0]               timer_value
);
  localparam int IW = $clog2(N_APPROACH);
  localparam int EW = $clog2(MAX_EXT + 2);
  localparam logic [3*N_APPROACH-1:0] RST_LIGHTS = {{(N_APPROACH-1){3'b100}}, 3'b001};
  typedef enum logic [1:0] {GREEN = 2'b00, ORANGE = 2'b01, ALLRED = 2'b10} phase_t;
  phase_t                  phase_q, phase_d;
  logic [IW-1:0]           idx_q, idx_d, win;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic [EW-1:0]           ext_q, ext_d;
  logic [3*N_APPROACH-1:0] lights_q, lights_d;
  logic [SENSOR_W-1:0]     best;
  logic                    emg_ok, emg_hold, act_max, last, preempt;
  int                      j;
  always_comb begin
    emg_ok   = emg_req && int'(emg_sel) < N_APPROACH;
    emg_hold = emg_ok && emg_sel == idx_q;
    last     = timer_q == TIMER_W'(1);
    preempt  = emg_ok && !emg_hold && int'(timer_q) <= GREEN_TIME - MIN_GREEN;
    act_max  = 1'b1;
    for (int i = 0; i < N_APPROACH; i++)
      if (IW'(i) != idx_q && sensor[i*SENSOR_W +: SENSOR_W] >= sensor[int'(idx_q)*SENSOR_W +: SENSOR_W])
        act_max = 1'b0;
    best = '0;
    win  = idx_q;
    j    = 0;
    for (int k = 1; k < N_APPROACH; k++) begin
      j = (int'(idx_q) + k) % N_APPROACH;
      if (k == 1 || sensor[j*SENSOR_W +: SENSOR_W] > best) begin
        best = sensor[j*SENSOR_W +: SENSOR_W];
        win  = IW'(j);
      end
    end
    if (emg_ok && !emg_hold)
      win = emg_sel;
    phase_d = phase_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    ext_d   = ext_q;
    if (tick) begin
      case (phase_q)
        GREEN: begin
          if (preempt || (last && !emg_hold && !(act_max && int'(ext_q) < MAX_EXT))) begin
            phase_d = ORANGE;
            timer_d = TIMER_W'(ORANGE_TIME);
            ext_d   = '0;
          end else if (last) begin
            timer_d = TIMER_W'(GREEN_TIME);
            ext_d   = emg_hold ? EW'(0) : ext_q + EW'(1);
          end else
            timer_d = timer_q - TIMER_W'(1);
        end
        ORANGE: begin
          phase_d = last ? ALLRED : ORANGE;
          timer_d = last ? TIMER_W'(ALLRED_TIME) : timer_q - TIMER_W'(1);
        end
        ALLRED: begin
          phase_d = last ? GREEN : ALLRED;
          timer_d = last ? TIMER_W'(GREEN_TIME) : timer_q - TIMER_W'(1);
          idx_d   = last ? win : idx_q;
          ext_d   = last ? EW'(0) : ext_q;
        end
        default: begin
          phase_d = GREEN;
          timer_d = TIMER_W'(GREEN_TIME);
        end
      endcase
    end
    lights_d = '0;
    for (int i = 0; i < N_APPROACH; i++)
      lights_d[3*i +: 3] = IW'(i) != idx_d ? 3'b100 :
                           phase_d == GREEN ? 3'b001 :
                           phase_d == ORANGE ? 3'b010 : 3'b100;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= GREEN;
      idx_q    <= '0;
      timer_q  <= TIMER_W'(GREEN_TIME);
      ext_q    <= '0;
      lights_q <= RST_LIGHTS;
    end else begin
      phase_q  <= phase_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      ext_q    <= ext_d;
      lights_q <= lights_d;
    end
  end
  assign lights      = lights_q;
  assign active_idx  = idx_q;
  assign phase       = phase_q;
  assign timer_value = timer_q;
endmodule
